// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment display logic
package seg7_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  typedef logic [2:0] digit_idx_t;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_t;
endpackage

// File: rtl/hex7seg.sv
// hex7seg: hex nibble to active-low abcdefg segment pattern (seg_o[6] = a)
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered 8-digit multiplexed seven-segment driver
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  en_mask,
  output logic [7:0]  AN,
  output logic [6:0]  A2G,
  output logic        DP,
  output logic        frame_done,
  output logic        pending
);
  if (NUM_DIGITS != seg7_pkg::NUM_DIGITS) $error("seg7_scan_driver supports only 8 digits");
  if (SCAN_DIV < 2) $error("SCAN_DIV must be at least 2");
  if (BLANK_CYC >= SCAN_DIV) $error("BLANK_CYC must be less than SCAN_DIV");

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  disp_t         shd_q, shd_d, act_q, act_d;
  logic          pend_q, pend_d, fd_q, fd_d, dp_q, dp_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    a2g_q, a2g_d, seg;
  logic          wrap, boundary, blank;

  hex7seg u_hex (.hex_i(act_q.data[{idx_q, 2'b00} +: 4]), .seg_o(seg));

  assign wrap     = cnt_q == CNT_LAST;
  assign boundary = wrap && idx_q == 3'd7;
  assign blank    = cnt_q < CNT_BLANK || !act_q.en[idx_q];

  // The swap reads pend_q/shd_q, so a load in the boundary cycle waits a frame
  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 1'b1 : idx_q;
    act_d  = (boundary && pend_q) ? shd_q : act_q;
    shd_d  = load ? '{data: data, dp: dp_mask, en: en_mask} : shd_q;
    pend_d = load || (pend_q && !boundary);
    fd_d   = boundary;
    an_d   = blank ? AN_OFF : ~(8'b1 << idx_q);
    a2g_d  = blank ? SEG_BLANK : seg;
    dp_d   = blank || !act_q.dp[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      shd_q  <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
      fd_q   <= 1'b0;
      an_q   <= AN_OFF;
      a2g_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      shd_q  <= shd_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      fd_q   <= fd_d;
      an_q   <= an_d;
      a2g_q  <= a2g_d;
      dp_q   <= dp_d;
    end
  end

  assign AN         = an_q;
  assign A2G        = a2g_q;
  assign DP         = dp_q;
  assign frame_done = fd_q;
  assign pending    = pend_q;
endmodule
